// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: register offsets, CON bit positions
// and the transmit sequencer state encoding.
package uart_pkg;

    localparam logic [3:0] TXD_OFS = 4'h6;
    localparam logic [3:0] RXD_OFS = 4'h7;
    localparam logic [3:0] CON_OFS = 4'h8;

    localparam int unsigned CON_TX_READY   = 0;
    localparam int unsigned CON_RX_VALID   = 1;
    localparam int unsigned CON_RX_OVERRUN = 2;
    localparam int unsigned CON_TX_BUSY    = 3;
    localparam int unsigned CON_RX_IE      = 4;
    localparam int unsigned CON_TX_IE      = 5;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_controller_if.sv
// CPU bus and UART transmitter/receiver signals of the UART controller.
// The slave modport is the controller; the master modport is its environment.
interface uart_controller_if;

    logic        sel;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_status;
    logic        rx_status;
    logic [7:0]  rx_data;
    logic        irq;

    modport master (
        output sel, rd, wr, addr, wdata, tx_status, rx_status, rx_data,
        input  rdata, tx_en, tx_data, irq
    );

    modport slave (
        input  sel, rd, wr, addr, wdata, tx_status, rx_status, rx_data,
        output rdata, tx_en, tx_data, irq
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO. DEPTH must be a power of two so the pointers wrap naturally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped UART controller: queues TX bytes and sequences the external transmitter,
// latches RX bytes with valid/overrun flags and raises a level interrupt.
module uart_controller
    import uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter logic [3:0]  ADDR_TXD = TXD_OFS,
    parameter logic [3:0]  ADDR_RXD = RXD_OFS,
    parameter logic [3:0]  ADDR_CON = CON_OFS
) (
    input  logic            sysclk,
    input  logic            reset,
    uart_controller_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TX_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic        wait_cnt_q, wait_cnt_d;
    logic [7:0]  tx_data_q;

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    logic [7:0]  rx_buf_q, rx_buf_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        rx_ie_q, rx_ie_d;
    logic        tx_ie_q, tx_ie_d;
    logic        irq_q, irq_d;

    logic [3:0]  reg_sel;
    logic        txd_wr, rxd_rd, con_wr, tx_busy;
    logic        unused_bits;

    assign reg_sel     = bus.addr[5:2];
    assign txd_wr      = bus.sel & bus.wr & (reg_sel == ADDR_TXD);
    assign rxd_rd      = bus.sel & bus.rd & (reg_sel == ADDR_RXD);
    assign con_wr      = bus.sel & bus.wr & (reg_sel == ADDR_CON);
    assign tx_busy     = (state_q != IDLE) | (fifo_count != '0);
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (txd_wr),
        .pop    (fifo_pop),
        .din    (bus.wdata[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // TX sequencer: state register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // TX sequencer: next state. A transmitter that never shows busy is assumed
    // to have taken the byte after two cycles in WAIT_BUSY.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && bus.tx_status) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                wait_cnt_d = 1'b0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_status || wait_cnt_q) state_d = WAIT_DONE;
                else wait_cnt_d = 1'b1;
            end
            WAIT_DONE: begin
                if (bus.tx_status) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // TX sequencer: outputs.
    always_comb begin
        bus.tx_en   = (state_q == START);
        bus.tx_data = tx_data_q;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) tx_data_q <= 8'h00;
        else if (fifo_pop) tx_data_q <= fifo_dout;
    end

    // RX capture and CON updates; a new byte takes priority over a coincident RXD read.
    always_comb begin
        rx_buf_d     = rx_buf_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        rx_ie_d      = rx_ie_q;
        tx_ie_d      = tx_ie_q;
        if (rxd_rd) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end
        if (con_wr) begin
            rx_ie_d = bus.wdata[CON_RX_IE];
            tx_ie_d = bus.wdata[CON_TX_IE];
            if (bus.wdata[CON_RX_OVERRUN]) rx_overrun_d = 1'b0;
        end
        if (bus.rx_status) begin
            rx_buf_d   = bus.rx_data;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rxd_rd) rx_overrun_d = 1'b1;
        end
        irq_d = (rx_ie_q & rx_valid_q) | (tx_ie_q & ~tx_busy);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_buf_q     <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ie_q      <= 1'b0;
            tx_ie_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            rx_buf_q     <= rx_buf_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_ie_q      <= rx_ie_d;
            tx_ie_q      <= tx_ie_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.sel) begin
            if (reg_sel == ADDR_RXD) begin
                bus.rdata = {24'h0, rx_buf_q};
            end else if (reg_sel == ADDR_CON) begin
                bus.rdata[CON_TX_READY]   = ~fifo_full;
                bus.rdata[CON_RX_VALID]   = rx_valid_q;
                bus.rdata[CON_RX_OVERRUN] = rx_overrun_q;
                bus.rdata[CON_TX_BUSY]    = tx_busy;
                bus.rdata[CON_RX_IE]      = rx_ie_q;
                bus.rdata[CON_TX_IE]      = tx_ie_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_controller.sv
// Self-checking bench for uart_controller: transmitter model, TX byte scoreboard,
// and per-feature scenario tasks.
module tb_uart_controller;

    localparam logic [5:0] A_TXD = 6'h18;
    localparam logic [5:0] A_RXD = 6'h1C;
    localparam logic [5:0] A_CON = 6'h20;
    localparam int         FRAME = 8;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    uart_controller_if bus ();

    uart_controller dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int tx_pulses = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    // Transmitter model: busy for FRAME cycles after each start pulse, or while forced.
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    assign bus.tx_status = ~force_busy && (busy_cnt == 0);

    always @(posedge sysclk) begin
        if (bus.tx_en) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Scoreboard: every start pulse must match the oldest expected byte.
    always @(negedge sysclk) begin
        if (!reset && bus.tx_en) begin
            tx_pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got tx_en with tx_data=%02h, want no pulse",
                         bus.tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.tx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL tx_byte: got %02h want %02h", bus.tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge sysclk); #1;
        bus.sel = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.rd = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        @(posedge sysclk); #1;
        bus.sel = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        bus.rx_status = 1'b1; bus.rx_data = b;
        @(posedge sysclk); #1;
        bus.rx_status = 1'b0;
    endtask

    task automatic check_reg(input logic [5:0] a, input logic [31:0] want, input string name);
        logic [31:0] d;
        bus_read(a, d);
        total++;
        if (d !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, d, want);
        end
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin idle(1); n++; end
        idle(2);
        while (!bus.tx_status && n < limit) begin idle(1); n++; end
        idle(1);
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s: got timeout after %0d cycles want drained", name, n);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        total++;
        if ({bus.tx_en, bus.tx_data, bus.irq} !== 10'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %03h want 000", {bus.tx_en, bus.tx_data, bus.irq});
        end
        check_reg(A_CON, 32'h01, "reset_con");
        check_reg(A_TXD, 32'h00, "txd_read_zero");
        bus.sel = 1'b0; bus.rd = 1'b1; bus.addr = A_CON;
        #1 d = bus.rdata;
        bus.rd = 1'b0;
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL unselected_rdata: got %08h want 00000000", d);
        end
        idle(1);
    endtask

    task automatic test_single_tx;
        int p0 = tx_pulses;
        exp_q.push_back(8'h55);
        bus_write(A_TXD, 32'h55);
        total++;
        if (bus.tx_en !== 1'b0) begin
            bad++; $display("FAIL single_tx_early: got tx_en=%b want 0", bus.tx_en);
        end
        idle(1);
        total++;
        if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h55) begin
            bad++;
            $display("FAIL single_tx_latency: got tx_en=%b data=%02h want 1/55",
                     bus.tx_en, bus.tx_data);
        end
        check_reg(A_CON, 32'h09, "single_tx_busy");
        wait_drain(100, "single_tx_drain");
        check_reg(A_CON, 32'h01, "single_tx_idle");
        total++;
        if (tx_pulses - p0 != 1 || bus.tx_data !== 8'h55) begin
            bad++;
            $display("FAIL single_tx_count: got %0d pulses data=%02h want 1/55",
                     tx_pulses - p0, bus.tx_data);
        end
    endtask

    task automatic test_back_to_back;
        int p0 = tx_pulses;
        force_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            bus_write(A_TXD, 32'(i));
        end
        check_reg(A_CON, 32'h08, "burst_full");
        bus_write(A_TXD, 32'h05);
        check_reg(A_CON, 32'h08, "burst_drop");
        idle(2);
        total++;
        if (tx_pulses != p0) begin
            bad++; $display("FAIL burst_hold: got %0d pulses want 0", tx_pulses - p0);
        end
        force_busy = 1'b0;
        wait_drain(300, "burst_drain");
        total++;
        if (tx_pulses - p0 != 4) begin
            bad++; $display("FAIL burst_count: got %0d pulses want 4", tx_pulses - p0);
        end
        check_reg(A_CON, 32'h01, "burst_idle");
    endtask

    task automatic test_rx;
        rx_pulse(8'hA3);
        check_reg(A_CON, 32'h03, "rx_con_valid");
        check_reg(A_RXD, 32'hA3, "rx_data");
        check_reg(A_CON, 32'h01, "rx_con_cleared");
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        check_reg(A_CON, 32'h07, "ovr_set");
        check_reg(A_RXD, 32'h22, "ovr_newest");
        check_reg(A_CON, 32'h01, "ovr_cleared");
        // RXD read in the same cycle as a new byte
        rx_pulse(8'h11);
        bus.sel = 1'b1; bus.rd = 1'b1; bus.addr = A_RXD;
        bus.rx_status = 1'b1; bus.rx_data = 8'h22;
        #1 d = bus.rdata;
        @(posedge sysclk); #1;
        bus.sel = 1'b0; bus.rd = 1'b0; bus.rx_status = 1'b0;
        total++;
        if (d !== 32'h11) begin
            bad++; $display("FAIL coincide_old: got %08h want 00000011", d);
        end
        check_reg(A_CON, 32'h03, "coincide_con");
        check_reg(A_RXD, 32'h22, "coincide_new");
        rx_pulse(8'h44);
        rx_pulse(8'h55);
        bus_write(A_CON, 32'h04);
        check_reg(A_CON, 32'h03, "ovr_con_clear");
        check_reg(A_RXD, 32'h55, "ovr_con_data");
    endtask

    task automatic test_irq;
        logic [31:0] d;
        bus_write(A_CON, 32'h10);
        rx_pulse(8'h5A);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL irq_registered: got %b want 0", bus.irq);
        end
        idle(1);
        total++;
        if (bus.irq !== 1'b1) begin
            bad++; $display("FAIL irq_rx: got %b want 1", bus.irq);
        end
        bus_read(A_RXD, d);
        idle(1);
        total++;
        if (bus.irq !== 1'b0 || d !== 32'h5A) begin
            bad++; $display("FAIL irq_rx_clear: got irq=%b rxd=%08h want 0/5A", bus.irq, d);
        end
        bus_write(A_CON, 32'h20);
        idle(1);
        total++;
        if (bus.irq !== 1'b1) begin
            bad++; $display("FAIL irq_tx_idle: got %b want 1", bus.irq);
        end
        check_reg(A_CON, 32'h21, "irq_con");
        bus_write(A_CON, 32'h00);
        idle(1);
        total++;
        if (bus.irq !== 1'b0) begin
            bad++; $display("FAIL irq_off: got %b want 0", bus.irq);
        end
    endtask

    task automatic test_reset_mid;
        int p0 = tx_pulses;
        int n  = 0;
        exp_q.push_back(8'h31);
        bus_write(A_TXD, 32'h31);
        while (tx_pulses == p0 && n < 20) begin idle(1); n++; end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL reset_mid_start: got no tx_en want pulse");
        end
        idle(2);
        for (int i = 2; i <= 4; i++) bus_write(A_TXD, 32'h30 + 32'(i));
        check_reg(A_CON, 32'h09, "reset_mid_queued");
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.tx_en !== 1'b0 || bus.tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_out: got tx_en=%b data=%02h want 0/00",
                     bus.tx_en, bus.tx_data);
        end
        exp_q.delete();
        @(posedge sysclk); #1 reset = 1'b0;
        check_reg(A_CON, 32'h01, "reset_mid_con");
        p0 = tx_pulses;
        idle(30);
        total++;
        if (tx_pulses != p0) begin
            bad++; $display("FAIL reset_mid_quiet: got %0d pulses want 0", tx_pulses - p0);
        end
        // Reset during the start pulse itself must drop tx_en at once
        exp_q.push_back(8'h77);
        bus_write(A_TXD, 32'h77);
        idle(1);
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus.tx_en !== 1'b0) begin
            bad++; $display("FAIL reset_start_drop: got tx_en=%b want 0", bus.tx_en);
        end
        exp_q.delete();
        @(posedge sysclk); #1 reset = 1'b0;
        idle(5);
    endtask

    initial begin
        bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 6'h0; bus.wdata = 32'h0;
        bus.rx_status = 1'b0; bus.rx_data = 8'h0;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx();
        test_overrun();
        test_irq();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
